store_merge_unit: RTL and testbench

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/store_merge_unit.sv | 138 +++++++++++++
 tb/tb_store_merge_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Sub-word store unit: turns SW/SH/SB requests into word-wide memory writes.
// SW writes straight through; SH/SB perform a read-modify-write of the
// enclosing word. Misaligned or reserved requests raise addr_err instead.
// Every output is decoded from the state register and latched registers only.
module store_merge_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              addr_err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [1:0] OP_RS = 2'b11;

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic [31:0] word_q;   // write data: raw wdata for SW, merged word for SH/SB
  logic        accept;
  logic        bad;

  logic [NUM_LANES-1:0]            lane_en;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_src;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes;
  logic [NUM_LANES-1:0][VEC_W-1:0] merged;

  assign accept = (state == IDLE) && req;

  // Classify the incoming request: reserved op or misalignment for its size.
  always_comb begin
    bad = 1'b0;
    case (op)
      OP_SW:   bad = (addr[1:0] != 2'b00);
      OP_SH:   bad = addr[0];
      OP_RS:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  // Next-state decode; SW skips the read, sub-word stores go through READ/MERGE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad)             state_nxt = ERR;
          else if (op == OP_SW) state_nxt = WRITE;
          else                 state_nxt = READ;
        end
      end
      READ:    state_nxt = MERGE;
      MERGE:   state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte-lane enables and replicated source data from the latched request.
  always_comb begin
    lane_en  = '1;
    lane_src = req_q.wdata;
    case (req_q.op)
      OP_SB: begin
        lane_en  = 4'b0001 << req_q.addr[1:0];
        lane_src = {4{req_q.wdata[7:0]}};
      end
      OP_SH: begin
        lane_en  = req_q.addr[1] ? 4'b1100 : 4'b0011;
        lane_src = {2{req_q.wdata[15:0]}};
      end
      default: begin
        lane_en  = '1;
        lane_src = req_q.wdata;
      end
    endcase
  end

  assign rd_lanes = mem_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign merged[gi] = lane_en[gi] ? lane_src[gi] : rd_lanes[gi];
    end
  endgenerate

  // State register; reset abandons any in-flight store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch on acceptance; write word loaded at accept (SW) or MERGE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      word_q <= '0;
    end else if (accept) begin
      req_q  <= '{op: op, addr: addr, wdata: wdata};
      word_q <= wdata;
    end else if (state == MERGE) begin
      word_q <= merged;
    end
  end

  assign ready     = (state == IDLE);
  assign mem_rd    = (state == READ);
  assign mem_wr    = (state == WRITE);
  assign done      = (state == WRITE);
  assign addr_err  = (state == ERR);
  assign mem_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = word_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: directed literal cases plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_store_merge_unit;
  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        done;
  logic        addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .done(done), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents, keyed by word address; untouched words hash from address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return wa * 32'h9E37_79B1;
  endfunction

  function automatic logic is_err(input logic [1:0] o, input logic [31:0] a);
    if (o == 2'b11) return 1'b1;
    if (o == 2'b00 && a[1:0] != 2'b00) return 1'b1;
    if (o == 2'b01 && a[0]) return 1'b1;
    return 1'b0;
  endfunction

  // Little-endian sub-word insert computed from a shift and a mask.
  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [1:0] o,
                                            input logic [31:0] a, input logic [31:0] d);
    int sh;
    logic [31:0] m;
    if (o == 2'b10) begin
      sh = 8 * int'(a[1:0]);
      m  = 32'h0000_00FF << sh;
    end else if (o == 2'b01) begin
      sh = a[1] ? 16 : 0;
      m  = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    return (old & ~m) | ((d << sh) & m);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, described by its kind,
  // how many cycles it lasts after acceptance, and where we are in it.
  // kind 0 = error (1 cycle), 1 = SW (1 cycle), 2 = SH/SB (3 cycles).
  int          m_kind;
  int          m_len;
  int          m_c;
  logic        m_busy = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (m_c == m_len) begin
          if (m_kind != 0) mem[m_addr] = m_data;
          m_busy = 1'b0;
        end else begin
          m_c++;
        end
      end else if (req) begin
        m_busy = 1'b1;
        m_c    = 1;
        m_addr = {addr[31:2], 2'b00};
        if (is_err(op, addr)) begin
          m_kind = 0; m_len = 1;
        end else if (op == 2'b00) begin
          m_kind = 1; m_len = 1; m_data = wdata;
        end else begin
          m_kind = 2; m_len = 3;
          m_data = merge_ref(mem_word(m_addr), op, addr, wdata);
        end
      end
    end
  end

  // Memory read response: word available the cycle after mem_rd.
  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_rd) mem_rdata <= mem_word(mem_addr);
      else        mem_rdata <= $urandom;
    end
  end

  // Every-cycle compare of all outputs against the model.
  initial begin
    logic e_rd, e_wr, e_err;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst ready", ready, 1);
        chk("rst mem_rd", mem_rd, 0);
        chk("rst mem_wr", mem_wr, 0);
        chk("rst done", done, 0);
        chk("rst addr_err", addr_err, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
      end else begin
        e_rd  = m_busy && m_kind == 2 && m_c == 1;
        e_wr  = m_busy && ((m_kind == 1 && m_c == 1) || (m_kind == 2 && m_c == 3));
        e_err = m_busy && m_kind == 0 && m_c == 1;
        chk("ready", ready, !m_busy);
        chk("mem_rd", mem_rd, e_rd);
        chk("mem_wr", mem_wr, e_wr);
        chk("done", done, e_wr);
        chk("addr_err", addr_err, e_err);
        if (e_rd || e_wr) chk("mem_addr", mem_addr, m_addr);
        if (e_wr)         chk("mem_wdata", mem_wdata, m_data);
      end
    end
  end

  // Directed single request with hand-computed expectations; entered and
  // left just after a rising edge with the unit idle.
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err, input logic [31:0] ea, input logic [31:0] ed);
    int lat;
    lat = (exp_err || o == 2'b00) ? 1 : 3;
    req = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; op = 2'($urandom); addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 1 && lat == 3) chk("lit mem_rd", mem_rd, 1);
      if (c == lat) begin
        if (exp_err) begin
          chk("lit addr_err", addr_err, 1);
          chk("lit err no done", done, 0);
          chk("lit err no wr", mem_wr, 0);
        end else begin
          chk("lit mem_wr", mem_wr, 1);
          chk("lit done", done, 1);
          chk("lit mem_addr", mem_addr, ea);
          chk("lit mem_wdata", mem_wdata, ed);
        end
      end
      if (c == lat + 1) begin
        chk("lit ready after", ready, 1);
        chk("lit done pulse", done, 0);
        chk("lit err pulse", addr_err, 0);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
    #1;
    chk("async rst ready", ready, 1);
    chk("async rst mem_wdata", mem_wdata, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Full-word store.
    run(2'b00, 32'h100, 32'hDEADBEEF, 0, 32'h100, 32'hDEADBEEF);
    // Byte store into the top lane.
    mem[32'h100] = 32'h11223344;
    run(2'b10, 32'h103, 32'h0000_00AA, 0, 32'h100, 32'hAA223344);
    // Halfword stores, upper then lower.
    mem[32'h200] = 32'h11223344;
    run(2'b01, 32'h202, 32'hFFFF5566, 0, 32'h200, 32'h55663344);
    mem[32'h200] = 32'h11223344;
    run(2'b01, 32'h200, 32'hFFFF5566, 0, 32'h200, 32'h11225566);
    // Error cases.
    run(2'b01, 32'h201, 32'h1234, 1, 0, 0);
    run(2'b00, 32'h102, 32'h1234, 1, 0, 0);
    run(2'b11, 32'h100, 32'h1234, 1, 0, 0);

    // Inputs churning while busy must not disturb the latched request.
    mem[32'h200] = 32'h11223344;
    req = 1'b1; op = 2'b01; addr = 32'h202; wdata = 32'hFFFF5566;
    @(posedge clk); #1;
    for (int c = 1; c <= 3; c++) begin
      op = 2'($urandom_range(0, 2)); addr = 32'h100 + $urandom_range(0, 63); wdata = $urandom;
      @(negedge clk);
      if (c == 1) chk("churn mem_rd", mem_rd, 1);
      if (c == 3) begin
        chk("churn mem_wr", mem_wr, 1);
        chk("churn mem_wdata", mem_wdata, 32'h55663344);
      end
      @(posedge clk); #1;
    end
    op = 2'b00; addr = 32'h300; wdata = 32'h12345678;
    @(negedge clk);
    chk("churn idle ready", ready, 1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("churn next wr", mem_wr, 1);
    chk("churn next addr", mem_addr, 32'h300);
    chk("churn next data", mem_wdata, 32'h12345678);
    @(posedge clk); #1;

    // Reset while an SB sits in MERGE.
    mem[32'h100] = 32'h11223344;
    req = 1'b1; op = 2'b10; addr = 32'h101; wdata = 32'h77;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid rst ready", ready, 1);
    chk("mid rst mem_wr", mem_wr, 0);
    chk("mid rst mem_rd", mem_rd, 0);
    chk("mid rst done", done, 0);
    chk("mid rst mem_addr", mem_addr, 0);
    chk("mid rst mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post rst no wr", mem_wr, 0);
      @(posedge clk); #1;
    end
    run(2'b00, 32'h104, 32'hCAFEF00D, 0, 32'h104, 32'hCAFEF00D);

    // Random traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 600; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      op    = 2'($urandom);
      addr  = 32'h100 + $urandom_range(0, 31);
      wdata = $urandom;
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
